vr_packet_arbiter: RTL and testbench
====================================

Name: vr_packet_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready output channel between NUM_REQ packet requesters.
- The grant locks for a whole packet, until a beat with last=1 is accepted.
- The output is a registered stage. Payload is held stable while out_valid && !out_ready, so it meets the channel-stability properties the team checks with SVA.
- Sits in front of any single-consumer AXI-style stream sink.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- DATA_W, 32, payload width per requester.
- ID_W, $clog2(NUM_REQ) (min 1), width of out_id. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_ready  output  NUM_REQ  per-requester beat accepted.
- req_data  input  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  final beat of packet.
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink accepts the output beat.
- out_data  output  DATA_W  output payload.
- out_last  output  1  output beat is the final beat of its packet.
- out_id  output  ID_W  index of the requester that sourced the beat.
- busy  output  1  high while a grant is locked (state LOCK).

Behaviour:
- Reset (async assert, sync-released use):
  - out_valid=0, out_data=0, out_last=0, out_id=0, busy=0, req_ready=0.
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, LOCK.
  - IDLE: if any req_valid, pick the first requester with valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register it as gnt and go to LOCK. Nothing is accepted in IDLE.
  - LOCK: busy=1. Beat acceptance is defined below.
  - LOCK exits to IDLE in the cycle a beat with req_last[gnt]=1 is accepted; rr_ptr<=gnt in the same cycle.
- Beat acceptance:
  - load = !out_valid || out_ready.
  - req_ready[i] = (state==LOCK) && (i==gnt) && load. Combinational from out_ready; all other bits are 0.
  - Acceptance means req_valid[gnt] && req_ready[gnt]. It loads out_data, out_last and out_id=gnt, and sets out_valid=1.
  - Otherwise, if out_ready is high, out_valid<=0.
- Stability: while out_valid && !out_ready, out_valid, out_data, out_last and out_id do not change.
- Latency:
  - First beat: requester valid seen in IDLE at cycle N; req_ready is high at N+1; out_valid is high at N+2.
  - Steady state: 1 beat/cycle when out_ready is held high.
  - One dead arbitration cycle (IDLE) between packets, even with requests pending.
- Boundary conditions:
  - Granted requester deasserts valid mid-packet: the grant stays locked indefinitely (no timeout), and other requesters wait.
  - Non-granted requesters are never acknowledged, whatever their valid/last values.
  - Last beat accepted while the output still holds the previous beat: not possible. load is required for acceptance, so the output register never overflows.
  - Single-beat packet (last=1 on the first beat): LOCK lasts exactly one accepting cycle.
  - NUM_REQ=1: rr_ptr and gnt stay 0 and ID_W=1; behaviour is otherwise identical.
  - Reset asserted mid-packet: the in-flight output beat and the grant are discarded, and all outputs go to their reset values immediately.

Optional Feature:
- Macro: VR_PACKET_ARBITER_SVA_EN.
- When defined, embedded concurrent assertions are compiled in. Each uses @(posedge clk) disable iff (areset) and reports with $error on failure:
  - (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_last) && $stable(out_id) && out_valid)
  - $onehot0(req_ready)
  - (req_ready != 0) |-> busy
  - No req_ready bit outside gnt.
- When undefined: no assertions. RTL behaviour and ports are identical in both builds.

Test Plan:
- Reset then idle, all inputs 0: out_valid=0, busy=0, req_ready=0 for 10 cycles.
- Requester 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2+last) with out_ready=1:
  - Out beats appear on 3 consecutive cycles starting 2 cycles after req_valid.
  - out_id=2 on every beat; busy falls after the last beat.
- Requesters 0, 1 and 3 all hold 1-beat packets valid from reset: grant order is 0, 1, 3, then 0 again if it re-requests. out_id sequence is 0, 1, 3.
- Backpressure: out_ready=0 for 4 cycles while beat 0x55 is presented:
  - out_data=0x55 and out_valid=1 are held.
  - req_ready[gnt]=0 throughout.
  - Next beat 0x56 appears one cycle after out_ready rises.
- Mid-packet gap: granted requester 1 drops valid for 3 cycles while requester 0 is valid:
  - Requester 0 gets no ready; busy stays 1.
  - Requester 1 resumes and completes; requester 0 is granted after the one-cycle IDLE.
- areset pulsed while out_valid=1 mid-packet: outputs zero immediately. After release, requester 0 (if valid) wins first arbitration. Build also run with VR_PACKET_ARBITER_SVA_EN: zero assertion failures.

Source files
------------

// File: rtl/vr_packet_arbiter.sv
// vr_packet_arbiter: round-robin packet arbiter onto one registered valid/ready channel; define VR_PACKET_ARBITER_SVA_EN to compile embedded assertions
module vr_packet_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_id,
  output logic                      busy
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [ID_W-1:0] gnt, rr_ptr, pick, idx;
  logic load, accept;
  assign load = !out_valid || out_ready;
  assign accept = (state == LOCK) && req_valid[gnt] && load;
  assign busy = (state == LOCK);
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = busy && (gnt == ID_W'(i)) && load;
  end
  // nearest valid requester after rr_ptr; scanning farthest-first lets the closest one win
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      pick = req_valid[idx] ? idx : pick;
    end
  end
  // grant FSM and output register; the output only loads when empty or being drained
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_id <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= req_data[gnt*DATA_W +: DATA_W];
        out_last <= req_last[gnt];
        out_id <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE) begin
        if (|req_valid) begin
          gnt <= pick;
          state <= LOCK;
        end
      end else if (accept && req_last[gnt]) begin
        state <= IDLE;
        rr_ptr <= gnt;
      end
    end
  end
`ifdef VR_PACKET_ARBITER_SVA_EN
  a_stable: assert property (@(posedge clk) disable iff (areset)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_last) && $stable(out_id) && out_valid))
    else $error("output changed while stalled");
  a_onehot: assert property (@(posedge clk) disable iff (areset) $onehot0(req_ready))
    else $error("req_ready not onehot0");
  a_busy: assert property (@(posedge clk) disable iff (areset) (req_ready != '0) |-> busy)
    else $error("req_ready without busy");
  a_gnt: assert property (@(posedge clk) disable iff (areset) (req_ready & ~(NUM_REQ'(1) << gnt)) == '0)
    else $error("req_ready outside grant");
`endif
endmodule

// File: tb/tb_vr_packet_arbiter.sv
// tb_vr_packet_arbiter: directed and random checks of the packet arbiter against a queue-based model
module tb_vr_packet_arbiter;
  localparam int NR = 4, DW = 32, IW = 2;
  logic clk = 1'b0, areset = 1'b1, out_ready = 1'b0;
  logic [NR-1:0] req_valid = '0, req_last = '0, req_ready, hold = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic out_valid, out_last, busy;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  int checks = 0, errors = 0, cyc = 0;
  bit rnd_ready = 1'b0;
  logic [DW:0] src [NR][$];
  logic [IW+DW:0] obs [$];
  int obs_cyc [$];
  bit m_lock, m_ov, m_ol;
  int m_gnt, m_ptr, m_oid;
  logic [DW-1:0] m_od;

  always #5 clk = ~clk;

  vr_packet_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_last(req_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_id(out_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_gnt = 0; m_ptr = NR - 1; m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0;
  endtask

  // one clock: drive sources, compare at negedge, advance the model over the rising edge
  task automatic step();
    logic [DW:0] b;
    logic [NR-1:0] exp_rdy;
    bit load, acc;
    int pick;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NR; i++) begin
      b = {1'($urandom), DW'($urandom)};
      if (src[i].size() > 0) b = src[i][0];
      req_valid[i] = (src[i].size() > 0) && !hold[i];
      req_data[i*DW +: DW] = b[DW-1:0];
      req_last[i] = b[DW];
    end
    @(negedge clk);
    load = !m_ov || out_ready;
    acc = m_lock && req_valid[m_gnt] && load;
    exp_rdy = (m_lock && load) ? (NR'(1) << m_gnt) : '0;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("out_id", out_id, m_oid);
    chk("busy", busy, m_lock);
    chk("req_ready", req_ready, exp_rdy);
    if (out_valid && out_ready) begin
      obs.push_back({out_id, out_last, out_data});
      obs_cyc.push_back(cyc);
    end
    pick = -1;
    for (int k = 1; k <= NR; k++)
      if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
    if (acc) begin
      m_ov = 1; m_od = req_data[m_gnt*DW +: DW]; m_ol = req_last[m_gnt]; m_oid = m_gnt;
      void'(src[m_gnt].pop_front());
    end else if (out_ready) m_ov = 0;
    if (!m_lock) begin
      if (pick >= 0) begin m_gnt = pick; m_lock = 1; end
    end else if (acc && req_last[m_gnt]) begin
      m_lock = 0; m_ptr = m_gnt;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int t = 0;
    while (obs.size() < n && t < budget) begin step(); t++; end
    if (obs.size() < n) chk("timeout_obs", 64'(obs.size()), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t;
    int ids [4] = '{0, 1, 3, 0};
    logic [IW+DW:0] o, e;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    repeat (10) begin
      step();
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    n = cyc;
    src[2].push_back({1'b0, 32'hA0});
    src[2].push_back({1'b0, 32'hA1});
    src[2].push_back({1'b1, 32'hA2});
    repeat (8) step();
    chk("p2_beats", 64'(obs.size()), 3);
    for (int k = 0; k < 3; k++) if (k < obs.size()) begin
      e = {2'd2, 1'(k == 2), 32'(32'hA0 + k)};
      chk("p2_beat", obs[k], e);
      chk("p2_cycle", 64'(obs_cyc[k]), 64'(n + 2 + k));
    end
    chk("p2_busy_end", busy, 0);
    do_reset();
    obs.delete(); obs_cyc.delete();
    src[0].push_back({1'b1, 32'h10});
    src[0].push_back({1'b1, 32'h11});
    src[1].push_back({1'b1, 32'h20});
    src[3].push_back({1'b1, 32'h30});
    wait_obs(4, 40);
    for (int k = 0; k < 4; k++) if (k < obs.size()) begin
      o = obs[k];
      chk("rr_order", o[IW+DW:DW+1], 64'(ids[k]));
    end
    out_ready = 1'b0;
    src[1].push_back({1'b0, 32'h55});
    src[1].push_back({1'b1, 32'h56});
    t = 0;
    while (!out_valid && t < 20) begin step(); t++; end
    chk("bp_valid_seen", out_valid, 1);
    repeat (4) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h55);
      chk("bp_ready", req_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_data", out_data, 32'h56);
    chk("bp_next_valid", out_valid, 1);
    repeat (3) step();
    obs.delete(); obs_cyc.delete();
    src[1].push_back({1'b0, 32'hB0});
    src[1].push_back({1'b0, 32'hB1});
    src[1].push_back({1'b1, 32'hB2});
    step();
    step();
    hold[1] = 1'b1;
    src[0].push_back({1'b1, 32'hC0});
    repeat (3) begin
      step();
      chk("gap_busy", busy, 1);
      chk("gap_r0", req_ready[0], 0);
    end
    hold[1] = 1'b0;
    wait_obs(4, 30);
    if (obs.size() >= 4) begin
      o = obs[2];
      chk("gap_b2", o, {2'd1, 1'b1, 32'hB2});
      o = obs[3];
      chk("gap_c0", o, {2'd0, 1'b1, 32'hC0});
      chk("gap_idle_cycle", 64'(obs_cyc[3] - obs_cyc[2]), 2);
    end
    src[2].push_back({1'b0, 32'hD0});
    src[2].push_back({1'b0, 32'hD1});
    src[2].push_back({1'b1, 32'hD2});
    t = 0;
    while (!out_valid && t < 20) begin step(); t++; end
    chk("rst_pre_valid", out_valid, 1);
    areset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_id", out_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    model_reset();
    src[0].push_back({1'b1, 32'hE0});
    obs.delete(); obs_cyc.delete();
    @(posedge clk);
    #1;
    areset = 1'b0;
    wait_obs(1, 20);
    if (obs.size() >= 1) begin
      o = obs[0];
      chk("rst_first_winner", o, {2'd0, 1'b1, 32'hE0});
    end
    rnd_ready = 1'b1;
    repeat (3000) begin
      for (int i = 0; i < NR; i++) begin
        if (src[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) src[i].push_back({1'(j == n - 1), DW'($urandom)});
        end
        if ($urandom_range(0, 15) == 0) hold[i] = ~hold[i];
      end
      step();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    hold = '0;
    t = 0;
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() > 0 || out_valid) && t < 300) begin
      step();
      t++;
    end
    chk("drain_left", 64'(src[0].size() + src[1].size() + src[2].size() + src[3].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
